// File: rtl/roi_color_stats.sv
// ROI colour statistics: per-frame HSV mean over a power-of-two window, feature
// pixel count, and a one-shot colour capture producing tolerance bounds.
module roi_color_stats #(
  parameter int H_ACT        = 640,
  parameter int V_START_LINE = 1,
  parameter int V_END_LINE   = 479,
  parameter int W_LOG2       = 5,
  parameter int H_LOG2       = 5
) (
  input  logic        PClk,
  input  logic        Rst,
  input  logic [11:0] VtcHCnt,
  input  logic [11:0] VtcVCnt,
  input  logic [23:0] HSV24,
  input  logic        Binary_PostProcess,
  input  logic [11:0] Roi_X0,
  input  logic [11:0] Roi_Y0,
  input  logic [7:0]  Tol,
  input  logic        Extract_Req,
  input  logic        Color_Clear,
  output logic [23:0] HSV_Mean,
  output logic        Mean_Valid,
  output logic [23:0] HSV_Detect,
  output logic        Detect_Valid,
  output logic        Extract_Busy,
  output logic [23:0] HSV_Lo,
  output logic [23:0] HSV_Hi,
  output logic [20:0] Binary_Sum,
  output logic        Frame_Done
);

  localparam int ACC_W = 8 + W_LOG2 + H_LOG2;
  localparam int ROI_W = 1 << W_LOG2;
  localparam int ROI_H = 1 << H_LOG2;
  localparam int X_MAX = H_ACT - ROI_W;
  localparam int Y_MIN = V_START_LINE + 1;
  localparam int Y_MAX = V_END_LINE - ROI_H;
  localparam logic [20:0] CNT_MAX = '1;

  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;

  function automatic logic [11:0] clamp_x(input logic [11:0] x);
    if (int'(x) > X_MAX) return 12'(X_MAX);
    return x;
  endfunction

  function automatic logic [11:0] clamp_y(input logic [11:0] y);
    if (int'(y) < Y_MIN) return 12'(Y_MIN);
    if (int'(y) > Y_MAX) return 12'(Y_MAX);
    return y;
  endfunction

  function automatic logic [7:0] sat_sub(input logic [7:0] d, input logic [7:0] t);
    logic signed [9:0] r;
    r = $signed({2'b00, d}) - $signed({2'b00, t});
    if (r < 10'sd0) return 8'd0;
    return r[7:0];
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] d, input logic [7:0] t);
    logic signed [9:0] r;
    r = $signed({2'b00, d}) + $signed({2'b00, t});
    if (r > 10'sd255) return 8'hFF;
    return r[7:0];
  endfunction

  function automatic logic [20:0] sat_inc(input logic [20:0] c);
    return (c == CNT_MAX) ? c : c + 21'd1;
  endfunction

  logic             fs, fe, in_roi;
  logic [12:0]      x_end, y_end;
  logic [20:0]      cnt_inc;
  logic             sync_q;
  logic [11:0]      x0_q, y0_q;
  logic [ACC_W-1:0] acc_h_q, acc_s_q, acc_v_q;
  logic [20:0]      cnt_q;
  logic [23:0]      mean_q;
  logic             mean_vld_q;
  logic [20:0]      bsum_q;
  state_t           state_q, state_d;
  logic [23:0]      detect_q, detect_d;
  logic             det_vld_q, det_vld_d;
  logic             upd_q, upd_d;
  logic [23:0]      lo_q, hi_q;

  assign fs      = (VtcVCnt == 12'(V_START_LINE)) && (VtcHCnt == 12'd0);
  assign fe      = (VtcVCnt == 12'(V_END_LINE)) && (VtcHCnt == 12'd0);
  assign x_end   = {1'b0, x0_q} + 13'(ROI_W);
  assign y_end   = {1'b0, y0_q} + 13'(ROI_H);
  assign in_roi  = (VtcHCnt >= x0_q) && ({1'b0, VtcHCnt} < x_end) &&
                   (VtcVCnt >= y0_q) && ({1'b0, VtcVCnt} < y_end);
  assign cnt_inc = Binary_PostProcess ? sat_inc(cnt_q) : cnt_q;

  // Stage 0: ROI shadow, accumulation and feature count; sync_q waits for a frame start
  always_ff @(posedge PClk) begin
    if (Rst) begin
      sync_q  <= 1'b0;
      x0_q    <= '0;
      y0_q    <= '0;
      acc_h_q <= '0;
      acc_s_q <= '0;
      acc_v_q <= '0;
      cnt_q   <= '0;
    end else if (fs) begin
      sync_q  <= 1'b1;
      x0_q    <= clamp_x(Roi_X0);
      y0_q    <= clamp_y(Roi_Y0);
      acc_h_q <= '0;
      acc_s_q <= '0;
      acc_v_q <= '0;
      cnt_q   <= {20'd0, Binary_PostProcess};
    end else begin
      if (sync_q && in_roi) begin
        acc_h_q <= acc_h_q + {{(ACC_W-8){1'b0}}, HSV24[23:16]};
        acc_s_q <= acc_s_q + {{(ACC_W-8){1'b0}}, HSV24[15:8]};
        acc_v_q <= acc_v_q + {{(ACC_W-8){1'b0}}, HSV24[7:0]};
      end
      cnt_q <= cnt_inc;
    end
  end

  // Stage 1: frame-end results; the top 8 accumulator bits are the truncated mean
  always_ff @(posedge PClk) begin
    if (Rst) begin
      mean_vld_q <= 1'b0;
      mean_q     <= '0;
      bsum_q     <= '0;
    end else begin
      mean_vld_q <= fe && sync_q;
      if (fe && sync_q) begin
        mean_q <= {acc_h_q[ACC_W-1 -: 8], acc_s_q[ACC_W-1 -: 8], acc_v_q[ACC_W-1 -: 8]};
        bsum_q <= cnt_inc;
      end
    end
  end

  // Stage 2: capture control; clear wins over any request or capture
  always_comb begin
    state_d   = state_q;
    detect_d  = detect_q;
    det_vld_d = det_vld_q;
    upd_d     = 1'b0;
    if (Color_Clear) begin
      state_d   = IDLE;
      detect_d  = 24'hFFFFFF;
      det_vld_d = 1'b0;
      upd_d     = 1'b1;
    end else begin
      case (state_q)
        IDLE:  if (Extract_Req) state_d = ARMED;
        ARMED: if (mean_vld_q) begin
          state_d   = IDLE;
          detect_d  = mean_q;
          det_vld_d = 1'b1;
          upd_d     = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge PClk) begin
    if (Rst) begin
      state_q   <= IDLE;
      detect_q  <= 24'hFFFFFF;
      det_vld_q <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      detect_q  <= detect_d;
      det_vld_q <= det_vld_d;
      upd_q     <= upd_d;
    end
  end

  // Stage 3: bounds are refreshed only after a detect update, so Tol alone never moves them
  always_ff @(posedge PClk) begin
    if (Rst) begin
      lo_q <= 24'hFFFFFF;
      hi_q <= 24'hFFFFFF;
    end else if (upd_q) begin
      if (det_vld_q) begin
        lo_q <= {sat_sub(detect_q[23:16], Tol), sat_sub(detect_q[15:8], Tol),
                 sat_sub(detect_q[7:0], Tol)};
        hi_q <= {sat_add(detect_q[23:16], Tol), sat_add(detect_q[15:8], Tol),
                 sat_add(detect_q[7:0], Tol)};
      end else begin
        lo_q <= 24'hFFFFFF;
        hi_q <= 24'hFFFFFF;
      end
    end
  end

  assign HSV_Mean     = mean_q;
  assign Mean_Valid   = mean_vld_q;
  assign Frame_Done   = mean_vld_q;
  assign Binary_Sum   = bsum_q;
  assign HSV_Detect   = detect_q;
  assign Detect_Valid = det_vld_q;
  assign Extract_Busy = (state_q == ARMED);
  assign HSV_Lo       = lo_q;
  assign HSV_Hi       = hi_q;

endmodule

// File: tb/tb_roi_color_stats.sv
// Bench for roi_color_stats on a reduced 64-pixel, 50-line raster with a 32x4 ROI.
module tb_roi_color_stats;
  localparam int H_ACT = 64, V_START = 1, V_END = 46, WL = 5, HL = 2;
  localparam int H_TOT = 70, V_TOT = 50;

  logic        PClk = 1'b0;
  logic        Rst = 1'b1;
  logic [11:0] VtcHCnt = '0, VtcVCnt = '0;
  logic [23:0] HSV24 = '0;
  logic        Binary_PostProcess = 1'b0;
  logic [11:0] Roi_X0 = '0, Roi_Y0 = '0;
  logic [7:0]  Tol = '0;
  logic        Extract_Req = 1'b0, Color_Clear = 1'b0;
  logic [23:0] HSV_Mean, HSV_Detect, HSV_Lo, HSV_Hi;
  logic        Mean_Valid, Detect_Valid, Extract_Busy, Frame_Done;
  logic [20:0] Binary_Sum;

  always #5 PClk = ~PClk;

  roi_color_stats #(.H_ACT(H_ACT), .V_START_LINE(V_START), .V_END_LINE(V_END),
                    .W_LOG2(WL), .H_LOG2(HL)) dut (
    .PClk(PClk), .Rst(Rst), .VtcHCnt(VtcHCnt), .VtcVCnt(VtcVCnt), .HSV24(HSV24),
    .Binary_PostProcess(Binary_PostProcess), .Roi_X0(Roi_X0), .Roi_Y0(Roi_Y0),
    .Tol(Tol), .Extract_Req(Extract_Req), .Color_Clear(Color_Clear),
    .HSV_Mean(HSV_Mean), .Mean_Valid(Mean_Valid), .HSV_Detect(HSV_Detect),
    .Detect_Valid(Detect_Valid), .Extract_Busy(Extract_Busy), .HSV_Lo(HSV_Lo),
    .HSV_Hi(HSV_Hi), .Binary_Sum(Binary_Sum), .Frame_Done(Frame_Done));

  typedef struct {
    logic [23:0] mean;
    logic [20:0] bsum;
    longint      cyc;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0, n_fail = 0, n_pops = 0;
  longint      cyc = 0;
  logic [23:0] last_mean = '0;
  logic [20:0] last_bsum = '0;
  logic [11:0] roi_x = '0, roi_y = '0;
  int          mx0 = 0, my0 = 0, sh = 0, ss = 0, sv = 0, mcnt = 0;
  bit          synced_m = 1'b0;

  always @(posedge PClk) cyc <= cyc + 1;

  function automatic int clamp_x(input int x);
    return (x > H_ACT - 32) ? H_ACT - 32 : x;
  endfunction

  function automatic int clamp_y(input int y);
    if (y < V_START + 1) return V_START + 1;
    if (y > V_END - 4) return V_END - 4;
    return y;
  endfunction

  function automatic logic [23:0] bound(input logic [23:0] d, input int t, input bit hi);
    logic [23:0] r;
    for (int c = 0; c < 3; c++) begin
      int x;
      x = hi ? int'(d[c*8 +: 8]) + t : int'(d[c*8 +: 8]) - t;
      if (x < 0) x = 0;
      if (x > 255) x = 255;
      r[c*8 +: 8] = 8'(x);
    end
    return r;
  endfunction

  // Scoreboard consumer: every Mean_Valid must match a queued frame result
  always @(negedge PClk) begin
    if (Mean_Valid === 1'b1 || Frame_Done === 1'b1) begin
      exp_t e;
      n_cmp++;
      if (Frame_Done !== Mean_Valid) begin
        n_fail++;
        $display("FAIL frame_done: got %b, want %b (Mean_Valid)", Frame_Done, Mean_Valid);
      end
      n_cmp++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_mean_valid: got Mean_Valid=1 at cycle %0d, want no pulse", cyc);
      end else begin
        e = sbq.pop_front();
        n_pops++;
        last_mean = e.mean;
        last_bsum = e.bsum;
        n_cmp++;
        if (HSV_Mean !== e.mean) begin
          n_fail++;
          $display("FAIL hsv_mean: got %h, want %h", HSV_Mean, e.mean);
        end
        n_cmp++;
        if (Binary_Sum !== e.bsum) begin
          n_fail++;
          $display("FAIL binary_sum: got %0d, want %0d", Binary_Sum, e.bsum);
        end
        n_cmp++;
        if (cyc != e.cyc + 1) begin
          n_fail++;
          $display("FAIL mean_latency: got cycle %0d, want %0d", cyc, e.cyc + 1);
        end
      end
    end
  end

  // Drives one raster frame and models the expected per-frame result
  task automatic run_frame(input int mode, input logic [23:0] pin, input int bpp_n,
                           input int req_line, input int rst_line, input int hold_exp);
    logic [23:0] px;
    bit          b, fs, fe, inr;
    int          lin, cnt_new;
    exp_t        e;
    for (int v = 0; v < V_TOT; v++) begin
      for (int h = 0; h < H_TOT; h++) begin
        @(negedge PClk);
        if (hold_exp >= 0 && v == 24 && h == 0) begin
          n_cmp++;
          if (Binary_Sum !== 21'(hold_exp)) begin
            n_fail++;
            $display("FAIL binary_sum_hold: got %0d, want %0d", Binary_Sum, hold_exp);
          end
        end
        if (req_line >= 0 && v == req_line + 1 && h == 0) begin
          n_cmp++;
          if (Extract_Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_armed: got %b, want 1", Extract_Busy);
          end
        end
        fs = (v == V_START && h == 0);
        fe = (v == V_END && h == 0);
        if (v == 0 && h == 0) Roi_X0 = roi_x;
        else if (v == 20 && h == 0) Roi_X0 = roi_x + 12'd3;
        Roi_Y0 = roi_y;
        if (fs) begin
          mx0 = clamp_x(int'(roi_x));
          my0 = clamp_y(int'(roi_y));
        end
        inr = (h >= mx0) && (h < mx0 + 32) && (v >= my0) && (v < my0 + 4);
        case (mode)
          0:       px = inr ? pin : 24'hFFFFFF;
          1:       px = {8'(h + 72), 16'h0000};
          2:       px = {8'(h), 8'h55, 8'(v)};
          default: px = 24'($urandom);
        endcase
        lin = (v - 2) * H_TOT + h;
        b   = (lin >= 0 && lin < bpp_n);
        VtcHCnt = 12'(h);
        VtcVCnt = 12'(v);
        HSV24 = px;
        Binary_PostProcess = b;
        Extract_Req = (v == req_line && h == 0);
        Rst = (v == rst_line && h == 0);
        if (Rst) begin
          synced_m = 1'b0;
          mcnt = 0;
        end else begin
          cnt_new = fs ? int'(b) : ((b && mcnt < 2097151) ? mcnt + 1 : mcnt);
          if (fe && synced_m) begin
            e.mean = {8'(sh >> 7), 8'(ss >> 7), 8'(sv >> 7)};
            e.bsum = 21'(cnt_new);
            e.cyc  = cyc;
            sbq.push_back(e);
          end
          if (fs) begin
            synced_m = 1'b1;
            sh = 0; ss = 0; sv = 0;
          end else if (inr && synced_m) begin
            sh += int'(px[23:16]);
            ss += int'(px[15:8]);
            sv += int'(px[7:0]);
          end
          mcnt = cnt_new;
        end
      end
    end
    Extract_Req = 1'b0;
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] got24 [0:4];
    logic [23:0] want24[0:4];
    string       nm[0:4];
    Rst = 1'b1;
    repeat (3) @(negedge PClk);
    n_cmp++;
    if ({Mean_Valid, Frame_Done, Detect_Valid, Extract_Busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, want 0000",
               {Mean_Valid, Frame_Done, Detect_Valid, Extract_Busy});
    end
    n_cmp++;
    if (Binary_Sum !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_bsum: got %0d, want 0", Binary_Sum);
    end
    got24 = '{HSV_Mean, HSV_Detect, HSV_Lo, HSV_Hi, 24'h0};
    want24 = '{24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h0};
    nm = '{"reset_mean", "reset_detect", "reset_lo", "reset_hi", ""};
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got24[i] !== want24[i]) begin
        n_fail++;
        $display("FAIL %s: got %h, want %h", nm[i], got24[i], want24[i]);
      end
    end
    Rst = 1'b0;
  endtask

  task automatic test_const_mean();
    int p0;
    p0 = n_pops;
    roi_x = 12'd20; roi_y = 12'd10;
    run_frame(0, 24'h4080C0, 0, -1, -1, -1);
    n_cmp++;
    if (n_pops != p0 + 1 || last_mean !== 24'h4080C0) begin
      n_fail++;
      $display("FAIL const_mean: got %h (pulses %0d), want 4080c0 (1)", last_mean, n_pops - p0);
    end
  endtask

  task automatic test_ramp();
    roi_x = 12'd28; roi_y = 12'd10;
    run_frame(1, 24'h0, 0, -1, -1, -1);
    n_cmp++;
    if (last_mean !== 24'h730000) begin
      n_fail++;
      $display("FAIL ramp_mean: got %h, want 730000", last_mean);
    end
  endtask

  task automatic test_binary_clamp();
    roi_x = 12'd700; roi_y = 12'd10;
    run_frame(2, 24'h0, 1000, -1, -1, -1);
    n_cmp++;
    if (last_mean !== 24'h2F550B || last_bsum !== 21'd1000) begin
      n_fail++;
      $display("FAIL clamp_bsum: got %h/%0d, want 2f550b/1000", last_mean, last_bsum);
    end
    run_frame(2, 24'h0, 0, -1, -1, 1000);
    n_cmp++;
    if (last_bsum !== 21'd0) begin
      n_fail++;
      $display("FAIL bsum_zero: got %0d, want 0", last_bsum);
    end
  endtask

  task automatic test_extract();
    roi_x = 12'd20; roi_y = 12'd10;
    Tol = 8'h10;
    run_frame(0, 24'h0580FA, 0, 20, -1, -1);
    @(negedge PClk);
    n_cmp++;
    if (Extract_Busy !== 1'b0 || Detect_Valid !== 1'b1 || HSV_Detect !== 24'h0580FA) begin
      n_fail++;
      $display("FAIL capture: got busy=%b vld=%b det=%h, want 0 1 0580fa",
               Extract_Busy, Detect_Valid, HSV_Detect);
    end
    n_cmp++;
    if (HSV_Lo !== 24'h0070EA || HSV_Hi !== 24'h1590FF) begin
      n_fail++;
      $display("FAIL bounds: got %h/%h, want 0070ea/1590ff", HSV_Lo, HSV_Hi);
    end
    Tol = 8'h30;
    repeat (5) @(negedge PClk);
    n_cmp++;
    if (HSV_Lo !== 24'h0070EA || HSV_Hi !== 24'h1590FF) begin
      n_fail++;
      $display("FAIL tol_hold: got %h/%h, want 0070ea/1590ff", HSV_Lo, HSV_Hi);
    end
  endtask

  task automatic test_clear();
    Extract_Req = 1'b1;
    Color_Clear = 1'b1;
    @(negedge PClk);
    Extract_Req = 1'b0;
    Color_Clear = 1'b0;
    n_cmp++;
    if (HSV_Detect !== 24'hFFFFFF || Detect_Valid !== 1'b0 || Extract_Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear: got det=%h vld=%b busy=%b, want ffffff 0 0",
               HSV_Detect, Detect_Valid, Extract_Busy);
    end
    n_cmp++;
    if (HSV_Lo !== 24'h0070EA) begin
      n_fail++;
      $display("FAIL clear_lo_latency: got %h, want 0070ea", HSV_Lo);
    end
    @(negedge PClk);
    n_cmp++;
    if (HSV_Lo !== 24'hFFFFFF || HSV_Hi !== 24'hFFFFFF) begin
      n_fail++;
      $display("FAIL clear_bounds: got %h/%h, want ffffff/ffffff", HSV_Lo, HSV_Hi);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] xs[0:2];
    logic [11:0] ys[0:2];
    xs = '{12'd5, 12'd9, 12'd31};
    ys = '{12'd0, 12'd100, 12'd45};
    for (int f = 0; f < 3; f++) begin
      roi_x = xs[f]; roi_y = ys[f];
      run_frame(3, 24'h0, int'($urandom_range(0, 3000)), (f == 0) ? 3 : -1, -1, -1);
      if (f == 0) begin
        @(negedge PClk);
        n_cmp++;
        if (HSV_Detect !== last_mean || Detect_Valid !== 1'b1) begin
          n_fail++;
          $display("FAIL rand_capture: got %h/%b, want %h/1", HSV_Detect, Detect_Valid, last_mean);
        end
        n_cmp++;
        if (HSV_Lo !== bound(last_mean, 48, 1'b0) || HSV_Hi !== bound(last_mean, 48, 1'b1)) begin
          n_fail++;
          $display("FAIL rand_bounds: got %h/%h, want %h/%h", HSV_Lo, HSV_Hi,
                   bound(last_mean, 48, 1'b0), bound(last_mean, 48, 1'b1));
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int p0;
    p0 = n_pops;
    roi_x = 12'd20; roi_y = 12'd10;
    run_frame(2, 24'h0, 500, -1, 24, -1);
    @(negedge PClk);
    n_cmp++;
    if (n_pops != p0 || HSV_Mean !== 24'h0 || Binary_Sum !== 21'd0 || Detect_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_frame: got pulses=%0d mean=%h bsum=%0d vld=%b, want 0 0 0 0",
               n_pops - p0, HSV_Mean, Binary_Sum, Detect_Valid);
    end
    run_frame(2, 24'h0, 0, -1, -1, -1);
    n_cmp++;
    if (n_pops != p0 + 1 || last_mean !== 24'h23550B) begin
      n_fail++;
      $display("FAIL post_reset_mean: got %h (pulses %0d), want 23550b (1)", last_mean, n_pops - p0);
    end
  endtask

  initial begin
    test_reset();
    test_const_mean();
    test_ramp();
    test_binary_clamp();
    test_extract();
    test_clear();
    test_back_to_back();
    test_mid_reset();
    repeat (4) @(negedge PClk);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL missing_mean_valid: got %0d pending, want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
